am_mod: RTL

AM_MOD -- requirements
Module: am_mod

---
 rtl/am_mod_pkg.sv | 27 ++
 rtl/am_mod_seq_mult.sv | 54 +++++
 rtl/am_mod.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/am_mod_pkg.sv
// Shared definitions for the AM modulator: FSM encoding, saturation limit and
// the load_tick-to-out_tick latency.
package am_mod_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_ENV = 3'd1,
        ST_CLAMP   = 3'd2,
        ST_MUL_I   = 3'd3,
        ST_MUL_Q   = 3'd4,
        ST_OUT     = 3'd5
    } state_t;

    localparam int DEF_BITS = 16;

    function automatic int max_pos(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int latency(input int bits);
        return 3 * bits + 3;
    endfunction

    localparam int MAX_POS = max_pos(DEF_BITS);
    localparam int LATENCY = latency(DEF_BITS);

endpackage

// File: rtl/am_mod_seq_mult.sv
// Signed BITS x BITS shift-add multiplier. The start edge already folds in
// multiplier bit 0, so the exact product is ready (done pulse) BITS edges after start.
module seq_mult #(
    parameter int BITS = 16
) (
    input  logic                     CLK,
    input  logic                     RSTb,
    input  logic                     start,
    input  logic signed [BITS-1:0]   a,
    input  logic signed [BITS-1:0]   b,
    output logic signed [2*BITS-1:0] product,
    output logic                     done
);

    localparam int CW = $clog2(BITS + 1);

    logic signed [2*BITS-1:0] acc;
    logic signed [2*BITS-1:0] mcand;
    logic signed [2*BITS-1:0] a_ext;
    logic        [BITS-1:0]   mplr;
    logic        [CW-1:0]     cnt;

    assign a_ext   = {{BITS{a[BITS-1]}}, a};
    assign product = acc;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (start) begin
            acc   <= b[0] ? a_ext : '0;
            mcand <= a_ext <<< 1;
            mplr  <= {1'b0, b[BITS-1:1]};
            cnt   <= CW'(BITS - 1);
            done  <= 1'b0;
        end else if (cnt != '0) begin
            // The last step handles the multiplier sign bit, whose weight is negative.
            if (cnt == CW'(1))
                acc <= mplr[0] ? acc - mcand : acc;
            else
                acc <= mplr[0] ? acc + mcand : acc;
            mcand <= mcand <<< 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt - CW'(1);
            done  <= (cnt == CW'(1));
        end else begin
            done  <= 1'b0;
        end
    end

endmodule

// File: rtl/am_mod.sv
// AM modulator: envelope = carrier + audio*index, clamped, then mixed with a
// cos/sin LO pair into I/Q, all through one shared sequential multiplier.
module am_mod
    import am_mod_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    input  logic signed [BITS-1:0] audio_in,
    input  logic        [BITS-2:0] carrier_level,
    input  logic signed [BITS-1:0] mod_index,
    input  logic signed [BITS-1:0] cos_in,
    input  logic signed [BITS-1:0] sin_in,
    input  logic                   load_tick,
    input  logic                   overrun_clr,
    output logic signed [BITS-1:0] I_out,
    output logic signed [BITS-1:0] Q_out,
    output logic                   out_tick,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic signed [2*BITS-1:0] LIM     = (2*BITS)'(max_pos(BITS));
    localparam logic signed [BITS-1:0]   OUT_MAX = BITS'(max_pos(BITS));

    state_t state;
    logic   kick;
    logic   accept;

    logic signed [BITS-1:0]   audio_r, mod_r, cos_r, sin_r;
    logic        [BITS-2:0]   carrier_r;
    logic signed [BITS-1:0]   env_r, i_r, q_r;

    logic                     mul_start, mul_done;
    logic signed [BITS-1:0]   mul_a, mul_b;
    logic signed [2*BITS-1:0] mul_p;

    function automatic logic signed [BITS-1:0] clamp_env(
        input logic signed [2*BITS-1:0] p,
        input logic        [BITS-2:0]   car
    );
        logic signed [2*BITS-1:0] sum;
        sum = $signed({{(BITS+1){1'b0}}, car}) + (p >>> (BITS - 1));
        if (sum < 0)
            return '0;
        else if (sum > LIM)
            return OUT_MAX;
        else
            return sum[BITS-1:0];
    endfunction

    function automatic logic signed [BITS-1:0] sat_out(
        input logic signed [2*BITS-1:0] p
    );
        logic signed [2*BITS-1:0] scaled;
        scaled = p >>> (BITS - 1);
        if (scaled > LIM)
            return OUT_MAX;
        else if (scaled < -LIM)
            return -OUT_MAX;
        else
            return scaled[BITS-1:0];
    endfunction

    // busy stays high through the out_tick cycle, so a load there is refused.
    assign accept    = load_tick && !busy;
    assign mul_start = kick || (state == ST_CLAMP) || (state == ST_MUL_I && mul_done);

    always_comb begin
        mul_a = env_r;
        mul_b = cos_r;
        if (kick) begin
            mul_a = audio_r;
            mul_b = mod_r;
        end else if (state == ST_MUL_I) begin
            mul_b = sin_r;
        end
    end

    seq_mult #(.BITS(BITS)) u_mult (
        .CLK     (CLK),
        .RSTb    (RSTb),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .product (mul_p),
        .done    (mul_done)
    );

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state    <= ST_IDLE;
            kick     <= 1'b0;
            busy     <= 1'b0;
            out_tick <= 1'b0;
            overrun  <= 1'b0;
            I_out    <= '0;
            Q_out    <= '0;
        end else begin
            kick     <= 1'b0;
            out_tick <= 1'b0;
            if (load_tick && busy)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
            if (out_tick)
                busy <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_MUL_ENV;
                        kick  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_MUL_ENV: if (mul_done) state <= ST_CLAMP;
                ST_CLAMP:   state <= ST_MUL_I;
                ST_MUL_I:   if (mul_done) state <= ST_MUL_Q;
                ST_MUL_Q:   if (mul_done) state <= ST_OUT;
                ST_OUT: begin
                    state    <= ST_IDLE;
                    out_tick <= 1'b1;
                    I_out    <= i_r;
                    Q_out    <= q_r;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always written before use.
    always_ff @(posedge CLK) begin
        if (state == ST_IDLE && accept) begin
            audio_r   <= audio_in;
            carrier_r <= carrier_level;
            mod_r     <= mod_index;
            cos_r     <= cos_in;
            sin_r     <= sin_in;
        end
        if (state == ST_MUL_ENV && mul_done)
            env_r <= clamp_env(mul_p, carrier_r);
        if (state == ST_MUL_I && mul_done)
            i_r <= sat_out(mul_p);
        if (state == ST_MUL_Q && mul_done)
            q_r <= sat_out(mul_p);
    end

endmodule
